// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multi-cycle ARM-subset control unit with memory handshake timeout.
// Define MC_MUL_EN to add the two-cycle MUL execute state (EXECM).
module mc_controller_v2 #(
   parameter int ALUCTRL_W = 3,
   parameter int WAIT_W = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          Instr,
   input  logic [3:0]           ALUFlags,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 MemWrite,
   output logic                 RegWrite,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic [1:0]           RegSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ImmSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 MemErr,
   output logic [3:0]           State
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, EXECM = 4'd10
   } state_t;
   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
   localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);
   localparam logic [ALUCTRL_W-1:0] ALU_MUL = ALUCTRL_W'(5);
   state_t state, nxt;
   logic [WAIT_W-1:0] cnt;
   logic [3:0] flags;
   logic mul_cnt, cond_ex, timeout, mem_state, is_mul, exec_end, nz_ld, cv_ld;
   logic unused_bits;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cond, cmd;
   logic rd15, is_cmp, addsub, supported, fl_n, fl_z, fl_c, fl_v;
   logic [ALUCTRL_W-1:0] alu_dp;
   assign op = Instr[27:26];
   assign funct = Instr[25:20];
   assign cond = Instr[31:28];
   assign cmd = funct[4:1];
   assign rd15 = Instr[15:12] == 4'd15;
   assign unused_bits = ^{Instr[19:16], Instr[11:0]};
   assign {fl_n, fl_z, fl_c, fl_v} = flags;
   assign is_cmp = cmd == 4'b1010;
   assign addsub = cmd == 4'b0100 || cmd == 4'b0010 || is_cmp;
   assign supported = addsub || cmd == 4'b0000 || cmd == 4'b1100 || cmd == 4'b0001;
   assign alu_dp = cmd == 4'b0100 ? ALU_ADD :
                   (cmd == 4'b0010 || is_cmp) ? ALU_SUB :
                   cmd == 4'b0000 ? ALU_AND :
                   cmd == 4'b1100 ? ALU_ORR :
                   cmd == 4'b0001 ? ALU_EOR : ALU_ADD;
`ifdef MC_MUL_EN
   assign is_mul = op == 2'b00 && funct[5:1] == 5'b00000 && Instr[7:4] == 4'b1001;
`else
   assign is_mul = 1'b0;
`endif
   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};
   assign State = state;
   assign mem_state = state == FETCH || state == MEMRD || state == MEMWR;
   assign timeout = mem_state && cnt == WAIT_W'(TIMEOUT);
   assign MemErr = timeout;
   always_comb begin
      case (cond)
         4'b0000: cond_ex = fl_z;
         4'b0001: cond_ex = ~fl_z;
         4'b0010: cond_ex = fl_c;
         4'b0011: cond_ex = ~fl_c;
         4'b0100: cond_ex = fl_n;
         4'b0101: cond_ex = ~fl_n;
         4'b0110: cond_ex = fl_v;
         4'b0111: cond_ex = ~fl_v;
         4'b1000: cond_ex = fl_c & ~fl_z;
         4'b1001: cond_ex = ~fl_c | fl_z;
         4'b1010: cond_ex = fl_n == fl_v;
         4'b1011: cond_ex = fl_n != fl_v;
         4'b1100: cond_ex = ~fl_z & (fl_n == fl_v);
         4'b1101: cond_ex = fl_z | (fl_n != fl_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end
   always_comb begin
      nxt = state;
      case (state)
         FETCH:        nxt = (MemReady && !timeout) ? DECODE : FETCH;
         DECODE:       nxt = op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH : op == 2'b11 ? FETCH :
                             is_mul ? EXECM : funct[5] ? EXECI : EXECR;
         MEMADR:       nxt = funct[0] ? MEMRD : MEMWR;
         MEMRD:        nxt = timeout ? FETCH : MemReady ? MEMWB : MEMRD;
         MEMWR:        nxt = (timeout || MemReady) ? FETCH : MEMWR;
         EXECR, EXECI: nxt = is_cmp ? FETCH : ALUWB;
         EXECM:        nxt = mul_cnt ? ALUWB : EXECM;
         default:      nxt = FETCH;
      endcase
   end
   // flags latch as the execute state completes; MUL only ever touches N and Z
   assign exec_end = state == EXECR || state == EXECI || (state == EXECM && mul_cnt);
   assign nz_ld = exec_end && cond_ex && (state == EXECM ? funct[0] : supported && (funct[0] || is_cmp));
   assign cv_ld = exec_end && cond_ex && state != EXECM && supported && ((funct[0] && addsub) || is_cmp);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         cnt <= '0;
         flags <= '0;
         mul_cnt <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= (nxt == state && mem_state && !timeout) ? cnt + 1'b1 : '0;
         mul_cnt <= state == EXECM && !mul_cnt;
         if (nz_ld) flags[3:2] <= ALUFlags[3:2];
         if (cv_ld) flags[1:0] <= ALUFlags[1:0];
      end
   end
   always_comb begin
      PCWrite = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite = 1'b0;
      AdrSrc = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'b00;
      ResultSrc = 2'b00;
      ALUControl = ALU_ADD;
      case (state)
         FETCH: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ResultSrc = 2'b10;
            IRWrite = MemReady && !timeout;
            PCWrite = MemReady && !timeout;
         end
         DECODE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
         end
         MEMRD: AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite = cond_ex;
            PCWrite = cond_ex && rd15;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            MemWrite = cond_ex && !timeout;
         end
         EXECR: ALUControl = alu_dp;
         EXECI: begin
            ALUSrcB = 2'b01;
            ALUControl = alu_dp;
         end
         EXECM: ALUControl = ALU_MUL;
         ALUWB: begin
            RegWrite = cond_ex && supported && !is_cmp;
            PCWrite = cond_ex && supported && !is_cmp && rd15;
         end
         BRANCH: begin
            ALUSrcB = 2'b01;
            ResultSrc = 2'b10;
            PCWrite = cond_ex;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: directed and random instruction runs against an instruction-level model.
module tb_mc_controller_v2;
   localparam int TO = 15;
   logic clk = 1'b0, reset = 1'b1;
   logic [31:0] Instr = '0;
   logic [3:0] ALUFlags = '0;
   logic MemReady = 1'b0;
   logic PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, MemErr;
   logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;
   int vectors = 0, miscompares = 0;
   logic [3:0] mflags = '0;
   bit noise = 1'b0;
   logic [3:0] cmds [8] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001, 4'b0011, 4'b0111};

   mc_controller_v2 dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .MemErr(MemErr), .State(State)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ARM condition: pairs of codes share a base test, odd code inverts it
   function automatic bit cp(input logic [3:0] c, input logic [3:0] f);
      bit base;
      case (c[3:1])
         3'd0: base = f[2];
         3'd1: base = f[1];
         3'd2: base = f[3];
         3'd3: base = f[0];
         3'd4: base = f[1] & ~f[2];
         3'd5: base = f[3] == f[0];
         3'd6: base = ~f[2] & (f[3] == f[0]);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   // {mask, value} over {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} for each phase
   function automatic logic [11:0] mux_exp(input int st);
      case (st)
         0: return {6'b111111, 6'b011010};
         1: return {6'b011111, 6'b011010};
         2: return {6'b011100, 6'b000100};
         3: return {6'b100000, 6'b100000};
         4: return {6'b000011, 6'b000001};
         5: return {6'b100000, 6'b100000};
         7: return {6'b011100, 6'b000100};
         8: return {6'b000011, 6'b000000};
         9: return {6'b011111, 6'b000110};
         default: return {6'b011100, 6'b000000};
      endcase
   endfunction

   function automatic bit nz();
      return noise ? 1'($urandom_range(0, 1)) : 1'b1;
   endfunction

   task automatic cyc(input int st, input bit rdy, input logic [4:0] strb, input int alu);
      logic [11:0] t;
      MemReady = rdy;
      @(negedge clk);
      t = mux_exp(st);
      chk("state", 32'(State), 32'(st));
      chk("strobes_ir_pc_rw_mw_err", 32'({IRWrite, PCWrite, RegWrite, MemWrite, MemErr}), 32'(strb));
      if (alu >= 0) chk("alucontrol", 32'(ALUControl), 32'(alu));
      chk("muxes", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} & t[11:6]), 32'(t[5:0]));
      chk("decode", 32'({ImmSrc, RegSrc}), 32'({Instr[27:26], Instr[27:26] == 2'b01, Instr[27:26] == 2'b10}));
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic [3:0] af);
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] cmd, cd;
      bit rd15, sup, cmp, addsub, mul, c, rw;
      int alu;
      op = ins[27:26];
      fn = ins[25:20];
      cmd = ins[24:21];
      cd = ins[31:28];
      rd15 = ins[15:12] == 4'd15;
      Instr = ins;
      ALUFlags = af;
      for (int i = 0; i <= fw && i <= TO; i++)
         cyc(0, i == fw, (i == TO) ? 5'b00001 : (i == fw) ? 5'b11000 : 5'b00000, 0);
      if (fw > TO) return;
      cyc(1, nz(), 5'b0, 0);
      if (op == 2'b11) return;
      if (op == 2'b10) begin
         cyc(9, nz(), {1'b0, cp(cd, mflags), 3'b0}, 0);
         return;
      end
      if (op == 2'b01) begin
         cyc(2, nz(), 5'b0, fn[3] ? 0 : 1);
         c = cp(cd, mflags);
         for (int i = 0; i <= mw && i <= TO; i++)
            if (fn[0]) cyc(3, i == mw, (i == TO) ? 5'b00001 : 5'b0, -1);
            else cyc(5, i == mw, (i == TO) ? 5'b00001 : {3'b0, c, 1'b0}, -1);
         if (fn[0] && mw <= TO) cyc(4, nz(), {1'b0, c & rd15, c, 2'b0}, -1);
         return;
      end
      sup = 1'b1;
      addsub = 1'b0;
      case (cmd)
         4'b0100: begin alu = 0; addsub = 1'b1; end
         4'b0010, 4'b1010: begin alu = 1; addsub = 1'b1; end
         4'b0000: alu = 2;
         4'b1100: alu = 3;
         4'b0001: alu = 4;
         default: begin alu = 0; sup = 1'b0; end
      endcase
      cmp = cmd == 4'b1010;
      mul = 1'b0;
`ifdef MC_MUL_EN
      mul = fn[5:1] == 5'b0 && ins[7:4] == 4'b1001;
`endif
      c = cp(cd, mflags);
      if (mul) begin
         cyc(10, nz(), 5'b0, 5);
         cyc(10, nz(), 5'b0, 5);
         if (c && fn[0]) mflags[3:2] = af[3:2];
      end else begin
         cyc(fn[5] ? 7 : 6, nz(), 5'b0, alu);
         if (c && sup) begin
            if (fn[0] || cmp) mflags[3:2] = af[3:2];
            if ((fn[0] && addsub) || cmp) mflags[1:0] = af[1:0];
         end
      end
      if (cmp) return;
      rw = cp(cd, mflags) && sup;
      cyc(8, nz(), {1'b0, rw & rd15, rw, 2'b0}, -1);
   endtask

   initial begin
      logic [31:0] ins;
      int kind;
      #12;
      chk("reset_state", 32'(State), 32'd0);
      chk("reset_strobes", 32'({IRWrite, PCWrite, RegWrite, MemWrite, MemErr}), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run(32'hE0821003, 0, 0, 4'b0000);
      run(32'hE5912004, 0, 3, 4'b0000);
      run(32'hE5112004, 1, 2, 4'b0000);
      run(32'hE1510001, 0, 0, 4'b0100);
      run(32'h1AFFFFFE, 0, 0, 4'b0000);
      run(32'h0AFFFFFE, 0, 0, 4'b0000);
      run(32'hE0821003, 20, 0, 4'b0000);
      run(32'hE0821003, 16, 0, 4'b0000);
      run(32'hE0821003, 2, 0, 4'b0000);
      run(32'hE5912004, 0, 16, 4'b0000);
      run(32'hE5812004, 0, 16, 4'b0000);
      run(32'hE0010392, 0, 0, 4'b1000);
      run(32'hE1510001, 0, 0, 4'b0100);
      Instr = 32'hE5812004;
      cyc(0, 1'b1, 5'b11000, 0);
      cyc(1, 1'b1, 5'b0, 0);
      cyc(2, 1'b1, 5'b0, 0);
      MemReady = 1'b0;
      @(negedge clk);
      chk("memwr_before_reset", 32'({State, MemWrite}), 32'({4'd5, 1'b1}));
      #2 reset = 1'b1;
      #1;
      chk("memwrite_async_drop", 32'(MemWrite), 32'd0);
      chk("state_async_reset", 32'(State), 32'd0);
      mflags = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      run(32'h0AFFFFFE, 0, 0, 4'b0000);
      noise = 1'b1;
      for (int k = 0; k < 150; k++) begin
         kind = $urandom_range(0, 5);
         ins = $urandom;
         ins[31:28] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
         case (kind)
            0, 1: begin
               ins[27:26] = 2'b00;
               ins[25] = kind[0];
               ins[24:21] = cmds[$urandom_range(0, 7)];
               ins[4] = 1'b0;
            end
            2, 3: begin
               ins[27:26] = 2'b01;
               ins[20] = kind == 2;
            end
            4: ins[27:26] = 2'b10;
            default: ins[27:26] = 2'b11;
         endcase
         run(ins, $urandom_range(0, 4), $urandom_range(0, 4), 4'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
